seq_divider8: RTL
=================

Name: seq_divider8

Overview:
Multi-cycle unsigned integer divider for the microprocessor datapath; the inverse operation of the existing adder/multiplier arithmetic. Accepts a dividend/divisor pair with a start pulse and produces quotient and remainder by restoring shift-subtract, one quotient bit per clock. It sits beside the ALU and is driven by the control unit through a start/busy/done handshake.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits (legal range 2..32).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a division; sampled only in IDLE.
dividend  input  WIDTH  numerator; sampled on the accepting edge.
divisor  input  WIDTH  denominator; sampled on the accepting edge.
busy  output  1  high while an operation is in progress (RUN/SIGN states).
done  output  1  single-cycle pulse; quotient/remainder valid.
quotient  output  WIDTH  result quotient; held until the next accepted start.
remainder  output  WIDTH  result remainder; held until the next accepted start.
div_by_zero  output  1  set with done when divisor was 0; held with results.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal counter and shift registers cleared. Reset mid-operation aborts without a done pulse.
- States: IDLE, RUN, SIGN (only with the optional feature), DONE.
- IDLE: on an edge with start=1, latch operands, clear div_by_zero.
  - divisor==0: go to DONE; quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
  - otherwise: partial remainder P (WIDTH+1 bits)=0, Q=dividend, counter=WIDTH, go to RUN.
- RUN, each edge: T={P[WIDTH-1:0],Q[WIDTH-1]} minus {0,divisor}; if T is non-negative then P=T and shift 1 into Q LSB, else P={P[WIDTH-1:0],Q[WIDTH-1]} and shift 0; Q shifts left; counter decrements. When the counter reaches 0 after this edge, go to DONE (or to SIGN). Load quotient=Q and remainder=P[WIDTH-1:0].
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. A start seen while in DONE is ignored.
- Latency: done is high in the cycle following the WIDTH-th edge after the accepting edge. For WIDTH=8 that is 8 cycles after acceptance; for divide-by-zero, 1 cycle.
- busy=1 in every cycle where the state is RUN or SIGN. A start arriving while busy=1 is ignored, and operand changes have no effect.
- Back-to-back: the earliest next acceptance is the IDLE cycle after DONE (throughput of one operation per WIDTH+2 cycles).
- Invariant (unsigned): dividend == quotient*divisor + remainder and remainder < divisor.

Optional Feature:
Macro SIGNED_DIV_EN.
- Defined: operands are two's complement. Magnitudes are divided as above, then one extra SIGN cycle negates the quotient if the operand signs differ and negates the remainder if the dividend is negative (truncating division). Latency becomes WIDTH+1.
  - Most-negative / -1 returns quotient = most-negative value (wraps) and remainder=0, with no flag.
  - Divide-by-zero returns quotient=-1 and remainder=dividend, unchanged.
- Undefined: unsigned only, no SIGN state, latency WIDTH.

Test Plan:
- Reset, then start with 100/7 -> done exactly 8 cycles after acceptance, quotient=14 (0x0E), remainder=2, div_by_zero=0, busy high for 8 cycles.
- 5/0 -> done 1 cycle after acceptance, quotient=0xFF, remainder=0x05, div_by_zero=1. The next op 9/3 -> div_by_zero=0, quotient=3, remainder=0.
- 255/1 -> 255 r 0; 3/200 -> 0 r 3; 200/200 -> 1 r 0 (boundary operands).
- Start 100/7, then pulse start with 50/5 and change the operands while busy -> single done, result 14 r 2, second request not executed.
- Start 100/7, assert rst_n low at cycle 4 -> all outputs 0 immediately, no done pulse; after release 20/6 -> 3 r 2.
- With SIGNED_DIV_EN: -7/2 (0xF9/0x02) -> quotient 0xFD (-3), remainder 0xFF (-1), done after 9 cycles; -128/-1 -> 0x80 r 0.

Source files
------------

// File: rtl/seq_divider8.sv
// Multi-cycle restoring shift-subtract divider, one quotient bit per clock.
// Optional macro SIGNED_DIV_EN selects two's-complement operands (adds one SIGN cycle).
module seq_divider8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dvsr;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dz;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_last;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_p_nxt;
    logic [WIDTH-1:0] w_q_nxt;

`ifdef SIGNED_DIV_EN
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    logic r_neg_q;
    logic r_neg_r;

    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? f_neg(v) : v;
    endfunction
`endif

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dz;

    assign w_last = (r_cnt == CNT_ONE);

    // One restoring step: the partial remainder never exceeds the divisor, so WIDTH bits hold it.
    always_comb begin
        w_shift = {r_p, r_q[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_dvsr};
        if (!w_diff[WIDTH]) begin
            w_p_nxt = w_diff[WIDTH-1:0];
            w_q_nxt = {r_q[WIDTH-2:0], 1'b1};
        end else begin
            w_p_nxt = w_shift[WIDTH-1:0];
            w_q_nxt = {r_q[WIDTH-2:0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (divisor == ZERO_W) ? S_DONE : S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
`ifdef SIGNED_DIV_EN
                    w_state_nxt = S_SIGN;
`else
                    w_state_nxt = S_DONE;
`endif
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_SIGN:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state so busy/done come straight from flops.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            S_RUN, S_SIGN: w_busy_nxt = 1'b1;
            S_DONE:        w_done_nxt = 1'b1;
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Handshake output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p    <= ZERO_W;
            r_q    <= ZERO_W;
            r_dvsr <= ZERO_W;
            r_cnt  <= {CW{1'b0}};
            r_quot <= ZERO_W;
            r_rem  <= ZERO_W;
            r_dz   <= 1'b0;
`ifdef SIGNED_DIV_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dz <= 1'b0;
                        if (divisor == ZERO_W) begin
                            // Divide-by-zero: all-ones quotient, raw dividend as remainder.
                            r_quot <= ONES_W;
                            r_rem  <= dividend;
                            r_dz   <= 1'b1;
                        end else begin
                            r_p   <= ZERO_W;
                            r_cnt <= CNT_INIT;
`ifdef SIGNED_DIV_EN
                            r_q     <= f_abs(dividend);
                            r_dvsr  <= f_abs(divisor);
                            r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_neg_r <= dividend[WIDTH-1];
`else
                            r_q    <= dividend;
                            r_dvsr <= divisor;
`endif
                        end
                    end
                end
                S_RUN: begin
                    r_p   <= w_p_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt - CNT_ONE;
`ifndef SIGNED_DIV_EN
                    if (w_last) begin
                        r_quot <= w_q_nxt;
                        r_rem  <= w_p_nxt;
                    end
`endif
                end
                S_SIGN: begin
`ifdef SIGNED_DIV_EN
                    // Truncating division: remainder takes the dividend's sign.
                    r_quot <= r_neg_q ? f_neg(r_q) : r_q;
                    r_rem  <= r_neg_r ? f_neg(r_p) : r_p;
`endif
                end
                S_DONE: begin
                    r_cnt <= {CW{1'b0}};
                end
                default: begin
                    r_cnt <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule
